snes_joy_reader: RTL and testbench

- Console-side initiator for the SNES controller port serial protocol.
- Generates PORT_LATCH, PORT_CLK and PORT_P6 (IOBit), and samples the two active-low data lines PORT_DO[1:0].
- Assembles four 16-bit joypad words (pads 1/2 direct, pads 3/4 through a multitap), as the hardware auto-read does at vblank.
- Sits between the CPU I/O register block (the $4218-$421F equivalent) and the controller port pins.

---
 rtl/snes_joy_reader_if.sv | 32 +++
 rtl/snes_joy_reader.sv | 168 ++++++++++++++++
 tb/tb_snes_joy_reader.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/snes_joy_reader_if.sv
// Bus between the auto-read block and its neighbours: the CPU-side request and
// result signals plus the controller port pins.
//
// Handshake: START is a one-cycle request that is accepted only while BUSY=0;
// a request seen while BUSY=1 is dropped. DONE is a one-cycle pulse on the edge
// where JOY1..JOY4 take their new values, and BUSY is already 0 on that edge.
interface snes_joy_reader_if;
    logic        START;
    logic        MULTITAP;
    logic        BUSY;
    logic        DONE;
    logic        PORT_LATCH;
    logic        PORT_CLK;
    logic        PORT_P6;
    logic [1:0]  PORT_DO;
    logic [15:0] JOY1;
    logic [15:0] JOY2;
    logic [15:0] JOY3;
    logic [15:0] JOY4;

    // Side that drives requests and models the pads.
    modport master (
        output START, MULTITAP, PORT_DO,
        input  BUSY, DONE, PORT_LATCH, PORT_CLK, PORT_P6, JOY1, JOY2, JOY3, JOY4
    );

    // Reader side.
    modport slave (
        input  START, MULTITAP, PORT_DO,
        output BUSY, DONE, PORT_LATCH, PORT_CLK, PORT_P6, JOY1, JOY2, JOY3, JOY4
    );
endinterface

// File: rtl/snes_joy_reader.sv
// SNES controller port initiator. It latches the pads, clocks out 16 bits on
// both data lines and, when a multitap is selected, drops IOBit and reads a
// second 16-bit burst for pads 3/4. Results commit atomically at FINISH.
module snes_joy_reader #(
    parameter int LATCH_CYC = 12,
    parameter int HALF_CYC  = 6,
    parameter int P6_SETTLE = 4
) (
    input  logic               CLK,
    input  logic               RESET,
    snes_joy_reader_if.slave   bus,
    output logic [2:0]         state_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LATCH   = 3'd1,
        S_CLK_LO  = 3'd2,
        S_CLK_HI  = 3'd3,
        S_P6_WAIT = 3'd4,
        S_FINISH  = 3'd5
    } state_t;

    localparam logic [7:0] LATCH_LAST = 8'(LATCH_CYC - 1);
    localparam logic [7:0] HALF_LAST  = 8'(HALF_CYC - 1);
    localparam logic [7:0] P6_LAST    = 8'(P6_SETTLE - 1);

    state_t      state_q;
    logic [7:0]  cyc_q;
    logic [3:0]  bit_q;
    logic        phase_q;
    logic        mt_q;
    logic [15:0] sa_q, sb_q, s1_q, s2_q;
    logic        busy_q, done_q, latch_q, pclk_q, p6_q;
    logic [15:0] joy1_q, joy2_q, joy3_q, joy4_q;

    // Whole read sequence: state, timing counters, shadow shift registers and
    // every registered output live in this one block.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            phase_q <= 1'b0;
            mt_q    <= 1'b0;
            sa_q    <= '0;
            sb_q    <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            latch_q <= 1'b0;
            pclk_q  <= 1'b1;
            p6_q    <= 1'b1;
            joy1_q  <= '0;
            joy2_q  <= '0;
            joy3_q  <= '0;
            joy4_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.START) begin
                        state_q <= S_LATCH;
                        mt_q    <= bus.MULTITAP;
                        cyc_q   <= '0;
                        bit_q   <= '0;
                        phase_q <= 1'b0;
                        sa_q    <= '0;
                        sb_q    <= '0;
                        s1_q    <= '0;
                        s2_q    <= '0;
                        busy_q  <= 1'b1;
                        latch_q <= 1'b1;
                    end
                end
                S_LATCH: begin
                    if (cyc_q == LATCH_LAST) begin
                        // Latch drops on the same edge the clock goes low, so
                        // the two are never active together.
                        cyc_q   <= '0;
                        latch_q <= 1'b0;
                        pclk_q  <= 1'b0;
                        state_q <= S_CLK_LO;
                    end else begin
                        cyc_q <= cyc_q + 8'd1;
                    end
                end
                S_CLK_LO: begin
                    if (cyc_q == HALF_LAST) begin
                        // Sample just before the rising edge that shifts the pad.
                        sa_q    <= {sa_q[14:0], ~bus.PORT_DO[0]};
                        sb_q    <= {sb_q[14:0], ~bus.PORT_DO[1]};
                        cyc_q   <= '0;
                        pclk_q  <= 1'b1;
                        state_q <= S_CLK_HI;
                    end else begin
                        cyc_q <= cyc_q + 8'd1;
                    end
                end
                S_CLK_HI: begin
                    if (cyc_q == HALF_LAST) begin
                        cyc_q <= '0;
                        if (bit_q != 4'd15) begin
                            bit_q   <= bit_q + 4'd1;
                            pclk_q  <= 1'b0;
                            state_q <= S_CLK_LO;
                        end else if (!phase_q && mt_q) begin
                            // Park pads 1/2 and reuse the shifters for 3/4.
                            s1_q    <= sa_q;
                            s2_q    <= sb_q;
                            sa_q    <= '0;
                            sb_q    <= '0;
                            bit_q   <= '0;
                            p6_q    <= 1'b0;
                            state_q <= S_P6_WAIT;
                        end else begin
                            state_q <= S_FINISH;
                        end
                    end else begin
                        cyc_q <= cyc_q + 8'd1;
                    end
                end
                S_P6_WAIT: begin
                    if (cyc_q == P6_LAST) begin
                        cyc_q   <= '0;
                        phase_q <= 1'b1;
                        pclk_q  <= 1'b0;
                        state_q <= S_CLK_LO;
                    end else begin
                        cyc_q <= cyc_q + 8'd1;
                    end
                end
                S_FINISH: begin
                    if (mt_q) begin
                        joy1_q <= s1_q;
                        joy2_q <= s2_q;
                        joy3_q <= sa_q;
                        joy4_q <= sb_q;
                    end else begin
                        joy1_q <= sa_q;
                        joy2_q <= sb_q;
                        joy3_q <= '0;
                        joy4_q <= '0;
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    p6_q    <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // All outputs come straight from flops.
    assign bus.BUSY       = busy_q;
    assign bus.DONE       = done_q;
    assign bus.PORT_LATCH = latch_q;
    assign bus.PORT_CLK   = pclk_q;
    assign bus.PORT_P6    = p6_q;
    assign bus.JOY1       = joy1_q;
    assign bus.JOY2       = joy2_q;
    assign bus.JOY3       = joy3_q;
    assign bus.JOY4       = joy4_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_snes_joy_reader.sv
// Directed bench for snes_joy_reader with a behavioural pad/multitap model.
module tb_snes_joy_reader;

  localparam int L = 2;
  localparam int H = 2;
  localparam int S = 3;

  logic CLK;
  logic RESET;
  logic [2:0] state_dbg;
  snes_joy_reader_if bus_if();

  snes_joy_reader #(.LATCH_CYC(L), .HALF_CYC(H), .P6_SETTLE(S)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .bus(bus_if),
    .state_o(state_dbg)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // pad model: words are button masks (1 = pressed), lines are active low
  logic [15:0] w0, w1, w2, w3;
  logic [15:0] sr0, sr1;
  initial begin sr0 = 16'hFFFF; sr1 = 16'hFFFF; end
  always @(posedge CLK) if (bus_if.PORT_LATCH) begin sr0 = ~w0; sr1 = ~w1; end
  always @(posedge bus_if.PORT_CLK) begin sr0 = {sr0[14:0], 1'b1}; sr1 = {sr1[14:0], 1'b1}; end
  always @(negedge bus_if.PORT_P6) begin sr0 = ~w2; sr1 = ~w3; end
  assign bus_if.PORT_DO = {sr1[15], sr0[15]};

  int n_pass;
  int n_total;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // per-read observations
  int done_k, dones, falls, latch_cnt, overlap, p6_pre, early_change;
  logic p6_at_done;
  logic [15:0] joy1_before;

  // driver: one read; inject_k re-pulses START mid-read, abort_fall resets on that clock fall
  task automatic do_read(input logic mt, input int inject_k, input int abort_fall);
    logic prev_clk;
    bit   seen;
    int   limit;
    done_k = -1; dones = 0; falls = 0; latch_cnt = 0; overlap = 0;
    p6_pre = 0; early_change = 0; p6_at_done = 1'bx;
    joy1_before = bus_if.JOY1;
    prev_clk = 1'b1; seen = 0; limit = 400;
    bus_if.MULTITAP = mt;
    bus_if.START = 1'b1;
    for (int k = 0; k < limit; k++) begin
      @(posedge CLK); #1;
      if (k == 0) bus_if.START = 1'b0;
      if (k == 5) bus_if.MULTITAP = ~mt;
      if (k == inject_k) bus_if.START = 1'b1;
      if (k == inject_k + 1) bus_if.START = 1'b0;
      if (bus_if.PORT_LATCH) latch_cnt++;
      if (bus_if.PORT_LATCH && !bus_if.PORT_CLK) overlap++;
      if (prev_clk && !bus_if.PORT_CLK) falls++;
      if (!bus_if.PORT_P6 && !seen) begin
        if (prev_clk && !bus_if.PORT_CLK) seen = 1; else p6_pre++;
      end
      if (bus_if.DONE) begin
        dones++;
        if (done_k < 0) begin
          done_k = k; p6_at_done = bus_if.PORT_P6; limit = k + 6;
        end
      end else if (done_k < 0 && bus_if.JOY1 !== joy1_before) begin
        early_change++;
      end
      prev_clk = bus_if.PORT_CLK;
      if (abort_fall != 0 && falls == abort_fall) begin
        RESET = 1'b1; #1;
        check("abort_busy", 32'(bus_if.BUSY), 32'd0);
        check("abort_done", 32'(bus_if.DONE), 32'd0);
        check("abort_latch", 32'(bus_if.PORT_LATCH), 32'd0);
        check("abort_clk", 32'(bus_if.PORT_CLK), 32'd1);
        check("abort_p6", 32'(bus_if.PORT_P6), 32'd1);
        check("abort_joy1", 32'(bus_if.JOY1), 32'h0);
        check("abort_state", 32'(state_dbg), 32'd0);
        @(negedge CLK); RESET = 1'b0;
        break;
      end
    end
    bus_if.MULTITAP = 1'b0;
    bus_if.START = 1'b0;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    bus_if.START = 1'b0; bus_if.MULTITAP = 1'b0;
    w0 = 16'h0; w1 = 16'h0; w2 = 16'h0; w3 = 16'h0;
    RESET = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    // reset state
    check("rst_busy", 32'(bus_if.BUSY), 32'd0);
    check("rst_done", 32'(bus_if.DONE), 32'd0);
    check("rst_latch", 32'(bus_if.PORT_LATCH), 32'd0);
    check("rst_clk", 32'(bus_if.PORT_CLK), 32'd1);
    check("rst_p6", 32'(bus_if.PORT_P6), 32'd1);
    check("rst_joy1", 32'(bus_if.JOY1), 32'h0);
    check("rst_joy4", 32'(bus_if.JOY4), 32'h0);
    @(negedge CLK); RESET = 1'b0;
    @(negedge CLK);

    // reset during the 7th clock-low phase: no partial result
    w0 = 16'hA5C3; w1 = 16'h0F0F;
    do_read(1'b0, 1000, 7);
    check("abort_no_done", 32'(dones), 32'd0);

    // next read completes normally and preloads JOY1=1111
    w0 = 16'h1111; w1 = 16'h2222;
    do_read(1'b0, 1000, 0);
    check("pre_done_at", 32'(done_k), 32'(1 + L + 32*H));
    check("pre_joy1", 32'(bus_if.JOY1), 32'h1111);
    check("pre_joy2", 32'(bus_if.JOY2), 32'h2222);

    // plain read, START re-pulsed mid-burst and MULTITAP toggled mid-read
    w0 = 16'hA5C3; w1 = 16'h0F0F;
    do_read(1'b0, 20, 0);
    check("mt0_done_at", 32'(done_k), 32'(1 + L + 32*H));
    check("mt0_dones", 32'(dones), 32'd1);
    check("mt0_falls", 32'(falls), 32'd16);
    check("mt0_latch_cyc", 32'(latch_cnt), 32'(L));
    check("mt0_overlap", 32'(overlap), 32'd0);
    check("mt0_hold_joy1", 32'(early_change), 32'd0);
    check("mt0_joy1", 32'(bus_if.JOY1), 32'hA5C3);
    check("mt0_joy2", 32'(bus_if.JOY2), 32'h0F0F);
    check("mt0_joy3", 32'(bus_if.JOY3), 32'h0);
    check("mt0_joy4", 32'(bus_if.JOY4), 32'h0);
    check("mt0_busy_end", 32'(bus_if.BUSY), 32'd0);

    // multitap read, START re-pulsed during the second burst
    w0 = 16'h1234; w1 = 16'h5678; w2 = 16'h9ABC; w3 = 16'hDEF0;
    do_read(1'b1, 80, 0);
    check("mt1_done_at", 32'(done_k), 32'(1 + L + 64*H + S));
    check("mt1_dones", 32'(dones), 32'd1);
    check("mt1_falls", 32'(falls), 32'd32);
    check("mt1_p6_settle", 32'(p6_pre), 32'(S));
    check("mt1_p6_done", 32'(p6_at_done), 32'd1);
    check("mt1_hold_joy1", 32'(early_change), 32'd0);
    check("mt1_joy1", 32'(bus_if.JOY1), 32'h1234);
    check("mt1_joy2", 32'(bus_if.JOY2), 32'h5678);
    check("mt1_joy3", 32'(bus_if.JOY3), 32'h9ABC);
    check("mt1_joy4", 32'(bus_if.JOY4), 32'hDEF0);

    // nothing attached: lines idle high, every word reads zero
    w0 = 16'h0; w1 = 16'h0; w2 = 16'h0; w3 = 16'h0;
    do_read(1'b1, 1000, 0);
    check("nodev_done_at", 32'(done_k), 32'(1 + L + 64*H + S));
    check("nodev_overlap", 32'(overlap), 32'd0);
    check("nodev_joy1", 32'(bus_if.JOY1), 32'h0);
    check("nodev_joy2", 32'(bus_if.JOY2), 32'h0);
    check("nodev_joy3", 32'(bus_if.JOY3), 32'h0);
    check("nodev_joy4", 32'(bus_if.JOY4), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
